// File: rtl/array_heap_pkg.sv
// array_heap_pkg: shared types for the array heap engine.
// Optional feature macro: ARRAY_HEAP_CLEAR_EN adds the CLEAR state, which zeroes a granted area.
package array_heap_pkg;

   typedef enum logic [2:0] {
      OP_ALLOC = 3'd0,
      OP_FREE  = 3'd1,
      OP_WRITE = 3'd2,
      OP_READ  = 3'd3,
      OP_SIZE  = 3'd4
   } op_e;

`ifdef ARRAY_HEAP_CLEAR_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RESP  = 2'd2
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RESP  = 2'd2
   } state_e;
`endif

   localparam logic RSP_OK  = 1'b0;
   localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/array_heap_free_stack.sv
// array_heap_free_stack: LIFO of freed array ids, reused most-recent-first.
// It holds one slot per array, so it cannot overflow while each live id is freed at most once.
module array_heap_free_stack #(
   parameter int NARRAYS = 4,
   parameter int IDW     = 2
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           push_i,
   input  logic           pop_i,
   input  logic [IDW-1:0] pushId_i,
   output logic           empty_o,
   output logic [IDW-1:0] top_o
);

   localparam int CW = $clog2(NARRAYS + 1);

   logic [IDW-1:0] stackMem [2**IDW];
   logic [CW-1:0]  count_q;
   logic [IDW-1:0] topIdx;

   // Point at the newest entry; this is only used when the stack is non-empty.
   always_comb begin
      topIdx = IDW'(count_q - CW'(1));
   end

   assign empty_o = (count_q == '0);
   assign top_o   = stackMem[topIdx];

   // Track the stack depth, with reset taking priority over push and pop.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else if (push_i) begin
         count_q <= count_q + CW'(1);
      end else if (pop_i) begin
         count_q <= count_q - CW'(1);
      end
   end

   // Store a pushed id in the next free slot; stale slots need no reset.
   always_ff @(posedge clock) begin
      if (push_i && !reset) begin
         stackMem[IDW'(count_q)] <= pushId_i;
      end
   end

endmodule

// File: rtl/array_heap_engine.sv
// array_heap_engine: a fixed pool of arrays carved from one single-port heap memory.
// Commands are accepted in IDLE, and each one produces a single held response.
// Optional feature macro: ARRAY_HEAP_CLEAR_EN zeroes a granted area before the ALLOC response.
module array_heap_engine
   import array_heap_pkg::*;
#(
   parameter int WIDTH   = 12,
   parameter int NARRAYS = 4,
   parameter int NAREA   = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [2:0]                 cmd_op,
   input  logic [$clog2(NARRAYS)-1:0] cmd_array,
   input  logic [$clog2(NAREA)-1:0]   cmd_index,
   input  logic [WIDTH-1:0]           cmd_data,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [WIDTH-1:0]           rsp_data,
   output logic                       rsp_error,
   output logic [$clog2(NARRAYS):0]   peak_allocs,
   output logic                       busy
);

   localparam int AW  = $clog2(NARRAYS);
   localparam int IW  = $clog2(NAREA);
   localparam int PW  = AW + 1;
   localparam int SW  = $clog2(NAREA + 1);
   localparam int HAW = $clog2(NARRAYS * NAREA);

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    rspData_q, rspData_d;
   logic                rspError_q, rspError_d;
   logic [PW-1:0]       peak_q, peak_d;
   logic [NARRAYS-1:0]  live_q, live_d;
   logic [SW-1:0]       size_q [NARRAYS];
   logic [SW-1:0]       size_d [NARRAYS];
`ifdef ARRAY_HEAP_CLEAR_EN
   logic [AW-1:0]       clrArray_q, clrArray_d;
   logic [IW-1:0]       clrIdx_q, clrIdx_d;
`endif

   logic [WIDTH-1:0]    heapMem [NARRAYS*NAREA];
   logic                heapWe;
   logic [HAW-1:0]      heapAddr;
   logic [WIDTH-1:0]    heapWdata;
   logic [HAW-1:0]      cmdAddr;

   logic                stackPush, stackPop, stackEmpty;
   logic [AW-1:0]       stackTop;
   logic                arrayOk, indexOk, accessOk;
   logic [AW-1:0]       grant;
   logic                grantOk;

   array_heap_free_stack #(
      .NARRAYS(NARRAYS),
      .IDW    (AW)
   ) freeStack (
      .clock   (clock),
      .reset   (reset),
      .push_i  (stackPush),
      .pop_i   (stackPop),
      .pushId_i(cmd_array),
      .empty_o (stackEmpty),
      .top_o   (stackTop)
   );

   assign cmd_ready   = (state_q == ST_IDLE);
   assign rsp_valid   = (state_q == ST_RESP);
   assign rsp_data    = rspData_q;
   assign rsp_error   = rspError_q;
   assign peak_allocs = peak_q;
   assign busy        = (state_q != ST_IDLE);

   // Decode the command's address and check its range and liveness.
   always_comb begin
      cmdAddr  = HAW'(int'(cmd_array) * NAREA + int'(cmd_index));
      arrayOk  = (int'(cmd_array) < NARRAYS);
      indexOk  = (int'(cmd_index) < NAREA);
      accessOk = arrayOk && indexOk && live_q[cmd_array];
   end

   // Next-state logic: run the accepted command, step through the clear, and hold the response.
   always_comb begin
      state_d    = state_q;
      rspData_d  = rspData_q;
      rspError_d = rspError_q;
      peak_d     = peak_q;
      live_d     = live_q;
      size_d     = size_q;
      stackPush  = 1'b0;
      stackPop   = 1'b0;
      heapWe     = 1'b0;
      heapAddr   = cmdAddr;
      heapWdata  = cmd_data;
      grant      = stackTop;
      grantOk    = 1'b0;
`ifdef ARRAY_HEAP_CLEAR_EN
      clrArray_d = clrArray_q;
      clrIdx_d   = clrIdx_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d    = ST_RESP;
               rspData_d  = '0;
               rspError_d = RSP_OK;
               case (cmd_op)
                  OP_ALLOC: begin
                     if (!stackEmpty) begin
                        stackPop = 1'b1;
                        grant    = stackTop;
                        grantOk  = 1'b1;
                     end else if (int'(peak_q) < NARRAYS) begin
                        grant    = AW'(peak_q);
                        peak_d   = peak_q + PW'(1);
                        grantOk  = 1'b1;
                     end else begin
                        rspError_d = RSP_ERR;
                     end
                     if (grantOk) begin
                        live_d[grant] = 1'b1;
                        size_d[grant] = '0;
                        rspData_d     = WIDTH'(grant);
`ifdef ARRAY_HEAP_CLEAR_EN
                        state_d    = ST_CLEAR;
                        clrArray_d = grant;
                        clrIdx_d   = '0;
`endif
                     end
                  end
                  OP_FREE: begin
                     if (arrayOk && live_q[cmd_array]) begin
                        stackPush         = 1'b1;
                        live_d[cmd_array] = 1'b0;
                     end else begin
                        rspError_d = RSP_ERR;
                     end
                  end
                  OP_WRITE: begin
                     if (accessOk) begin
                        heapWe = 1'b1;
                        if (int'(cmd_index) >= int'(size_q[cmd_array])) begin
                           size_d[cmd_array] = SW'(int'(cmd_index) + 1);
                        end
                     end else begin
                        rspError_d = RSP_ERR;
                     end
                  end
                  OP_READ: begin
                     if (accessOk) begin
                        rspData_d = heapMem[cmdAddr];
                     end else begin
                        rspError_d = RSP_ERR;
                     end
                  end
                  OP_SIZE: begin
                     if (arrayOk && live_q[cmd_array]) begin
                        rspData_d = WIDTH'(size_q[cmd_array]);
                     end else begin
                        rspError_d = RSP_ERR;
                     end
                  end
                  default: begin
                     rspError_d = RSP_ERR;
                  end
               endcase
            end
         end
`ifdef ARRAY_HEAP_CLEAR_EN
         ST_CLEAR: begin
            heapWe    = 1'b1;
            heapAddr  = HAW'(int'(clrArray_q) * NAREA + int'(clrIdx_q));
            heapWdata = '0;
            clrIdx_d  = clrIdx_q + IW'(1);
            if (clrIdx_q == IW'(NAREA - 1)) begin
               state_d = ST_RESP;
            end
         end
`endif
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Register the control state, with synchronous reset overriding any command.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         rspData_q  <= '0;
         rspError_q <= RSP_OK;
         peak_q     <= '0;
         live_q     <= '0;
         size_q     <= '{default: '0};
`ifdef ARRAY_HEAP_CLEAR_EN
         clrArray_q <= '0;
         clrIdx_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         rspData_q  <= rspData_d;
         rspError_q <= rspError_d;
         peak_q     <= peak_d;
         live_q     <= live_d;
         size_q     <= size_d;
`ifdef ARRAY_HEAP_CLEAR_EN
         clrArray_q <= clrArray_d;
         clrIdx_q   <= clrIdx_d;
`endif
      end
   end

   // Single-port heap write; contents survive reset.
   always_ff @(posedge clock) begin
      if (heapWe && !reset) begin
         heapMem[heapAddr] <= heapWdata;
      end
   end

endmodule

// File: tb/tb_array_heap_engine.sv
// tb_array_heap_engine: scoreboard bench for array_heap_engine.
// Expected responses come from a small behavioural model and are queued when each command is driven.
// Respects ARRAY_HEAP_CLEAR_EN in the same way as the design.
module tb_array_heap_engine;

   localparam int WIDTH   = 12;
   localparam int NARRAYS = 4;
   localparam int NAREA   = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = '0;
   logic [1:0]       cmd_array = '0;
   logic [1:0]       cmd_index = '0;
   logic [WIDTH-1:0] cmd_data = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_error;
   logic [2:0]       peak_allocs;
   logic             busy;

   array_heap_engine #(.WIDTH(WIDTH), .NARRAYS(NARRAYS), .NAREA(NAREA)) dut (
      .clock      (clock),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_array  (cmd_array),
      .cmd_index  (cmd_index),
      .cmd_data   (cmd_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_error  (rsp_error),
      .peak_allocs(peak_allocs),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      string      tag;
      logic [WIDTH-1:0] data;
      logic       err;
      int         lat;
   } expect_t;

   expect_t scoreboard [$];

`ifdef ARRAY_HEAP_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   int               checks = 0;
   int               failures = 0;
   int               mPeak;
   bit               mLive [NARRAYS];
   int               mSize [NARRAYS];
   int               mStack [$];
   logic [WIDTH-1:0] mHeap [NARRAYS*NAREA];

   // Count one comparison and report it if it does not match.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Reset the model; the heap is left alone, as it is in the design.
   task automatic modelReset();
      mPeak = 0;
      mStack.delete();
      for (int i = 0; i < NARRAYS; i++) begin
         mLive[i] = 1'b0;
         mSize[i] = 0;
      end
   endtask

   // Predict the response of one command and update the model.
   task automatic modelCommand(input int op, input int arr, input int idx, input logic [WIDTH-1:0] data,
                               output logic [WIDTH-1:0] expData, output logic expErr, output int expLat);
      int id;
      expData = '0;
      expErr  = 1'b0;
      expLat  = 1;
      case (op)
         0: begin
            id = -1;
            if (mStack.size() > 0) id = mStack.pop_back();
            else if (mPeak < NARRAYS) begin id = mPeak; mPeak++; end
            if (id < 0) expErr = 1'b1;
            else begin
               mLive[id] = 1'b1;
               mSize[id] = 0;
               expData = WIDTH'(id);
               if (CLEAR_EN) begin
                  expLat = NAREA + 1;
                  for (int k = 0; k < NAREA; k++) mHeap[id*NAREA+k] = '0;
               end
            end
         end
         1: begin
            if (mLive[arr]) begin mStack.push_back(arr); mLive[arr] = 1'b0; end
            else expErr = 1'b1;
         end
         2: begin
            if (mLive[arr]) begin
               mHeap[arr*NAREA+idx] = data;
               if (idx + 1 > mSize[arr]) mSize[arr] = idx + 1;
            end else expErr = 1'b1;
         end
         3: begin
            if (mLive[arr]) expData = mHeap[arr*NAREA+idx];
            else expErr = 1'b1;
         end
         4: begin
            if (mLive[arr]) expData = WIDTH'(mSize[arr]);
            else expErr = 1'b1;
         end
         default: expErr = 1'b1;
      endcase
   endtask

   // Drive one command, queue its expected response, and check the response when it arrives.
   // A nonzero hold keeps rsp_ready low for that many cycles and offers a stray command meanwhile.
   task automatic applyStimulus(input string tag, input int op, input int arr, input int idx,
                                input logic [WIDTH-1:0] data, input int hold);
      expect_t e;
      int lat;
      e.tag = tag;
      modelCommand(op, arr, idx, data, e.data, e.err, e.lat);
      scoreboard.push_back(e);
      cmd_valid = 1'b1;
      cmd_op    = 3'(op);
      cmd_array = 2'(arr);
      cmd_index = 2'(idx);
      cmd_data  = data;
      for (int c = 0; c < 20 && !cmd_ready; c++) begin
         @(posedge clock); #1;
      end
      if (!cmd_ready) checkOutput({tag, ".ready"}, 0, 1);
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
      e = scoreboard.pop_front();
      checkOutput({e.tag, ".valid"}, 32'(rsp_valid), 1);
      checkOutput({e.tag, ".data"}, 32'(rsp_data), 32'(e.data));
      checkOutput({e.tag, ".err"}, 32'(rsp_error), 32'(e.err));
      checkOutput({e.tag, ".lat"}, lat, e.lat);
      for (int h = 0; h < hold; h++) begin
         if (h == 0) begin
            cmd_valid = 1'b1;
            cmd_op    = 3'd2;
            cmd_array = 2'd0;
            cmd_index = 2'd0;
            cmd_data  = 12'd99;
         end
         @(posedge clock); #1;
         checkOutput({e.tag, ".holdValid"}, 32'(rsp_valid), 1);
         checkOutput({e.tag, ".holdData"}, 32'(rsp_data), 32'(e.data));
         checkOutput({e.tag, ".holdReady"}, 32'(cmd_ready), 0);
      end
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
   endtask

   // Apply a one-cycle reset and check every reset-visible output.
   task automatic doReset(input string tag);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      modelReset();
      checkOutput({tag, ".busy"}, 32'(busy), 0);
      checkOutput({tag, ".rspValid"}, 32'(rsp_valid), 0);
      checkOutput({tag, ".rspErr"}, 32'(rsp_error), 0);
      checkOutput({tag, ".rspData"}, 32'(rsp_data), 0);
      checkOutput({tag, ".peak"}, 32'(peak_allocs), 0);
      checkOutput({tag, ".cmdReady"}, 32'(cmd_ready), 1);
   endtask

   initial begin
      #1;
      doReset("rst0");

      // Basic write/read/size traffic, with a held READ response.
      applyStimulus("alloc0", 0, 0, 0, 0, 0);
      applyStimulus("wr00", 2, 0, 0, 12'd11, 0);
      applyStimulus("wr01", 2, 0, 1, 12'd22, 0);
      applyStimulus("alloc1", 0, 0, 0, 0, 0);
      applyStimulus("wr11", 2, 1, 1, 12'd33, 0);
      applyStimulus("rd00hold", 3, 0, 0, 0, 5);
      applyStimulus("rd00", 3, 0, 0, 0, 0);
      applyStimulus("rd01", 3, 0, 1, 0, 0);
      applyStimulus("rd11", 3, 1, 1, 0, 0);
      applyStimulus("size1", 4, 1, 0, 0, 0);
      applyStimulus("size0", 4, 0, 0, 0, 0);
      applyStimulus("illegal", 6, 0, 0, 0, 0);
      applyStimulus("wrDead", 2, 3, 0, 12'd5, 0);
      applyStimulus("sizeDead", 4, 2, 0, 0, 0);

      // Exhaust the pool, then reuse freed ids in LIFO order.
      doReset("rst1");
      for (int i = 0; i < NARRAYS; i++) applyStimulus($sformatf("allocN%0d", i), 0, 0, 0, 0, 0);
      applyStimulus("allocFull", 0, 0, 0, 0, 0);
      checkOutput("peakFull", 32'(peak_allocs), 32'(mPeak));
      applyStimulus("free2", 1, 2, 0, 0, 0);
      applyStimulus("free0", 1, 0, 0, 0, 0);
      applyStimulus("reuse0", 0, 0, 0, 0, 0);
      applyStimulus("reuse2", 0, 0, 0, 0, 0);
      applyStimulus("free0a", 1, 0, 0, 0, 0);
      applyStimulus("free0b", 1, 0, 0, 0, 0);
      checkOutput("peakReuse", 32'(peak_allocs), 4);

      // Stale or cleared contents after an area is reused.
      doReset("rst2");
      applyStimulus("alloc0s", 0, 0, 0, 0, 0);
      applyStimulus("alloc1s", 0, 0, 0, 0, 0);
      applyStimulus("wr13", 2, 1, 3, 12'd7, 0);
      applyStimulus("free1", 1, 1, 0, 0, 0);
      applyStimulus("realloc1", 0, 0, 0, 0, 0);
      applyStimulus("rd13", 3, 1, 3, 0, 0);
      checkOutput("rd13const", 32'(mHeap[1*NAREA+3]), CLEAR_EN ? 32'd0 : 32'd7);
      applyStimulus("size1s", 4, 1, 0, 0, 0);

      // Reset while an ALLOC is still in flight.
      doReset("rst3");
      cmd_valid = 1'b1;
      cmd_op    = 3'd0;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      checkOutput("abort.busyBefore", 32'(busy), 1);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      modelReset();
      checkOutput("abort.busy", 32'(busy), 0);
      checkOutput("abort.rspValid", 32'(rsp_valid), 0);
      checkOutput("abort.peak", 32'(peak_allocs), 0);
      applyStimulus("abort.alloc", 0, 0, 0, 0, 0);

      $display("[TB] %0d/%0d checks passed", checks - failures, checks);
      $finish;
   end

endmodule

// File: doc/array_heap_engine.md
ARRAY_HEAP_ENGINE -- requirements
Module: array_heap_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 12, memory element width in bits.
REQ-002 SHALL have parameter NARRAYS, default 4, maximum number of live arrays.
REQ-003 SHALL have parameter NAREA, default 4, elements per array area; heap depth = NARRAYS*NAREA.
REQ-004 SHALL have ports: clock  input  1  single clock, rising edge; reset  input  1  synchronous, active-high.
REQ-005 SHALL have ports: cmd_valid  input  1  command offered; cmd_ready  output  1  command accepted this cycle when both high.
REQ-006 SHALL have ports: cmd_op  input  3  ALLOC=0 FREE=1 WRITE=2 READ=3 SIZE=4, others illegal; cmd_array  input  clog2(NARRAYS)  array id; cmd_index  input  clog2(NAREA)  element index; cmd_data  input  WIDTH  write data.
REQ-007 SHALL have ports: rsp_valid  output  1  response held; rsp_ready  input  1  response consumed; rsp_data  output  WIDTH  result; rsp_error  output  1  command rejected.
REQ-008 SHALL have ports: peak_allocs  output  clog2(NARRAYS)+1  high-water count of arrays ever minted; busy  output  1  state not IDLE.

Function
REQ-009 SHALL implement states IDLE, CLEAR, RESP; cmd_ready = 1 only in IDLE with rsp_valid low.
REQ-010 SHALL, on accepted command in IDLE, execute it and enter RESP next cycle (latency 1) except ALLOC with clear enabled (REQ-023).
REQ-011 SHALL, in RESP, hold rsp_valid/rsp_data/rsp_error stable until rsp_ready high, then return to IDLE next cycle; rsp_ready in same cycle as rsp_valid rise completes the handshake that edge.
REQ-012 ALLOC SHALL pop the freed-array stack if non-empty (LIFO reuse), else mint id = peak_allocs and increment peak_allocs; size[id] set 0; rsp_data = id zero-extended.
REQ-013 ALLOC with stack empty and peak_allocs == NARRAYS SHALL set rsp_error = 1, rsp_data = 0, no state change.
REQ-014 FREE SHALL push cmd_array onto the freed stack and clear its live flag; FREE of a non-live id SHALL set rsp_error, no push.
REQ-015 WRITE SHALL store cmd_data at heap[cmd_array*NAREA + cmd_index] and set size = max(size, cmd_index+1); rsp_data = 0.
REQ-016 READ SHALL return heap[cmd_array*NAREA + cmd_index]; SIZE SHALL return size[cmd_array] zero-extended.
REQ-017 WRITE/READ/SIZE on non-live id, index >= NAREA (non-power-of-two NAREA), or illegal op SHALL set rsp_error, rsp_data = 0, no state change.
REQ-018 Freed stack SHALL hold NARRAYS entries and can never overflow since each live id is freed at most once.
REQ-019 cmd_valid while cmd_ready low SHALL have no effect; command fields sampled only on the accept edge.

Reset
REQ-020 reset SHALL, on the next rising clock edge, force state IDLE, rsp_valid 0, rsp_error 0, rsp_data 0, busy 0, peak_allocs 0, stack top 0, all live flags 0, all sizes 0.
REQ-021 reset mid-CLEAR or mid-RESP SHALL abandon the operation; pending response is lost; heap contents need not be cleared.
REQ-022 reset SHALL take priority over every command in the same cycle.

Configuration
REQ-023 With ARRAY_HEAP_CLEAR_EN defined, ALLOC SHALL enter CLEAR, zero the NAREA elements of the granted area one per cycle, then RESP (latency NAREA+1); failed ALLOC skips CLEAR.
REQ-024 Without ARRAY_HEAP_CLEAR_EN, CLEAR state SHALL be absent, ALLOC latency 1, reused areas retain stale data.

Structure
REQ-025 Package array_heap_pkg SHALL hold the op enum, state enum and response-error constants.
REQ-026 Freed-array LIFO SHALL be sub-module array_heap_free_stack (push, pop, empty, top) parametrised by NARRAYS and id width.
REQ-027 Heap SHALL be one inferred single-port array of NARRAYS*NAREA x WIDTH; one heap access per cycle.

Verification
REQ-028 Reset; ALLOC -> id 0; WRITE(0,0,11), WRITE(0,1,22); ALLOC -> id 1; WRITE(1,1,33); READ(0,0)=11, READ(0,1)=22, READ(1,1)=33, SIZE(1)=2.
REQ-029 ALLOC x4 -> ids 0..3, 5th ALLOC -> rsp_error 1, peak_allocs 4.
REQ-030 FREE 2, FREE 0; ALLOC -> 0, ALLOC -> 2 (LIFO); FREE 0 twice -> second rsp_error 1.
REQ-031 Hold rsp_ready low 5 cycles after a READ -> rsp_valid/rsp_data stable, cmd_ready 0 throughout.
REQ-032 With ARRAY_HEAP_CLEAR_EN: write 7 to array 1 idx 3, FREE 1, ALLOC -> 1 after NAREA+1 cycles, READ(1,3)=0; without macro READ(1,3)=7.
REQ-033 Assert reset during CLEAR -> next cycle busy 0, rsp_valid 0, peak_allocs 0; subsequent ALLOC -> id 0.
